// File: rtl/l2_tag_req_sequencer.sv
// Requester-side sequencer for the L2 tag bank: issues one lookup or flush at a time over
// the bank's flex channels, returns the way/state/inv_ack_cnt response and flags bank misbehaviour.
module l2_tag_req_sequencer #(
  parameter int TAG_W   = 15,
  parameter int SET_W   = 9,
  parameter int WAY_W   = 3,
  parameter int STATE_W = 3,
  parameter int INV_W   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [TAG_W-1:0]   req_tag,
  input  logic [SET_W-1:0]   req_set,
  input  logic [STATE_W-1:0] req_state,
  input  logic [INV_W-1:0]   req_inv_ack_cnt,
  input  logic               req_has_state,
  input  logic               req_has_inv,
  input  logic               flush_req_valid,
  output logic               flush_req_ready,
  output logic               flush_done,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WAY_W-1:0]   rsp_way,
  output logic [STATE_W-1:0] rsp_state,
  output logic [INV_W-1:0]   rsp_inv_ack_cnt,
  output logic               tag_in_valid,
  output logic               set_in_valid,
  output logic               state_in_valid,
  output logic               inv_ack_cnt_in_valid,
  input  logic               tag_in_ready,
  input  logic               set_in_ready,
  input  logic               state_in_ready,
  input  logic               inv_ack_cnt_in_ready,
  output logic [TAG_W-1:0]   tag_in,
  output logic [SET_W-1:0]   set_in,
  output logic [STATE_W-1:0] state_in,
  output logic [INV_W-1:0]   inv_ack_cnt_in,
  input  logic               way_out_valid,
  input  logic               state_out_valid,
  input  logic               inv_ack_cnt_out_valid,
  output logic               way_out_ready,
  output logic               state_out_ready,
  output logic               inv_ack_cnt_out_ready,
  input  logic [WAY_W-1:0]   way_out,
  input  logic [STATE_W-1:0] state_out,
  input  logic [INV_W-1:0]   inv_ack_cnt_out,
  output logic               flush_in_valid,
  input  logic               flush_in_ready,
  input  logic               flush_complete_valid,
  output logic               flush_complete_ready,
  output logic               err_protocol,
  output logic               err_timeout
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_RSP, S_HOLD_RSP, S_FLUSH_ISSUE, S_FLUSH_WAIT
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [TAG_W-1:0]   r_tag;
  logic [SET_W-1:0]   r_set;
  logic [STATE_W-1:0] r_req_state;
  logic [INV_W-1:0]   r_req_inv;
  logic               r_has_state, r_has_inv;
  logic               r_tag_sent, r_set_sent, r_state_sent, r_inv_sent;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic [WAY_W-1:0]   r_rsp_way;
  logic [STATE_W-1:0] r_rsp_state;
  logic [INV_W-1:0]   r_rsp_inv;
  logic               r_flush_done, r_err_protocol, r_err_timeout;
  logic               w_req_acc, w_issue_done, w_in_flush, w_proto_viol, w_timeout_hit;

  assign w_req_acc = (r_state == S_IDLE) && !flush_req_valid && req_valid;

  // A channel counts as sent once its ready was seen, including the ready seen this cycle.
  assign w_issue_done = (r_tag_sent | tag_in_ready) & (r_set_sent | set_in_ready) &
                        (!r_has_state | r_state_sent | state_in_ready) &
                        (!r_has_inv | r_inv_sent | inv_ack_cnt_in_ready);

  assign w_in_flush    = (r_state == S_FLUSH_ISSUE) || (r_state == S_FLUSH_WAIT);
  assign w_proto_viol  = (way_out_valid && (r_state != S_WAIT_RSP)) ||
                         (flush_complete_valid && (r_state != S_FLUSH_WAIT)) ||
                         (w_in_flush && (way_out_valid || state_out_valid || inv_ack_cnt_out_valid));
  assign w_timeout_hit = (r_state == S_WAIT_RSP) && (r_wait_cnt == CNT_W'(TIMEOUT)) && !way_out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_tag          <= '0;
      r_set          <= '0;
      r_req_state    <= '0;
      r_req_inv      <= '0;
      r_has_state    <= 1'b0;
      r_has_inv      <= 1'b0;
      r_tag_sent     <= 1'b0;
      r_set_sent     <= 1'b0;
      r_state_sent   <= 1'b0;
      r_inv_sent     <= 1'b0;
      r_wait_cnt     <= '0;
      r_rsp_way      <= '0;
      r_rsp_state    <= '0;
      r_rsp_inv      <= '0;
      r_flush_done   <= 1'b0;
      r_err_protocol <= 1'b0;
      r_err_timeout  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_flush_done   <= (r_state == S_FLUSH_WAIT) && flush_complete_valid;
      r_err_protocol <= r_err_protocol | w_proto_viol;
      r_err_timeout  <= r_err_timeout | w_timeout_hit;

      if (w_req_acc) begin
        r_tag        <= req_tag;
        r_set        <= req_set;
        r_req_state  <= req_state;
        r_req_inv    <= req_inv_ack_cnt;
        r_has_state  <= req_has_state;
        r_has_inv    <= req_has_inv;
        r_tag_sent   <= 1'b0;
        r_set_sent   <= 1'b0;
        r_state_sent <= 1'b0;
        r_inv_sent   <= 1'b0;
      end

      if (r_state == S_ISSUE) begin
        r_tag_sent   <= r_tag_sent | tag_in_ready;
        r_set_sent   <= r_set_sent | set_in_ready;
        r_state_sent <= r_state_sent | (r_has_state & state_in_ready);
        r_inv_sent   <= r_inv_sent | (r_has_inv & inv_ack_cnt_in_ready);
      end

      // Counter saturates at TIMEOUT; the FSM keeps waiting after flagging.
      if (r_state == S_WAIT_RSP) begin
        if (r_wait_cnt != CNT_W'(TIMEOUT)) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        if (state_out_valid)       r_rsp_state <= state_out;
        if (inv_ack_cnt_out_valid) r_rsp_inv   <= inv_ack_cnt_out;
        if (way_out_valid)         r_rsp_way   <= way_out;
      end else begin
        r_wait_cnt <= '0;
      end

      if ((r_state == S_HOLD_RSP) && rsp_ready) begin
        r_rsp_way   <= '0;
        r_rsp_state <= '0;
        r_rsp_inv   <= '0;
      end
    end
  end

  always_comb begin
    w_state_nxt           = r_state;
    req_ready             = 1'b0;
    flush_req_ready       = 1'b0;
    tag_in_valid          = 1'b0;
    set_in_valid          = 1'b0;
    state_in_valid        = 1'b0;
    inv_ack_cnt_in_valid  = 1'b0;
    way_out_ready         = 1'b0;
    state_out_ready       = 1'b0;
    inv_ack_cnt_out_ready = 1'b0;
    rsp_valid             = 1'b0;
    flush_in_valid        = 1'b0;
    flush_complete_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Gated by rst so every output reads 0 while reset is held.
        req_ready       = !flush_req_valid && !rst;
        flush_req_ready = !rst;
        if (flush_req_valid)  w_state_nxt = S_FLUSH_ISSUE;
        else if (req_valid)   w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        tag_in_valid         = !r_tag_sent;
        set_in_valid         = !r_set_sent;
        state_in_valid       = r_has_state && !r_state_sent;
        inv_ack_cnt_in_valid = r_has_inv && !r_inv_sent;
        if (w_issue_done) w_state_nxt = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        way_out_ready         = 1'b1;
        state_out_ready       = 1'b1;
        inv_ack_cnt_out_ready = 1'b1;
        if (way_out_valid) w_state_nxt = S_HOLD_RSP;
      end
      S_HOLD_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      S_FLUSH_ISSUE: begin
        flush_in_valid = 1'b1;
        if (flush_in_ready) w_state_nxt = S_FLUSH_WAIT;
      end
      S_FLUSH_WAIT: begin
        flush_complete_ready = 1'b1;
        if (flush_complete_valid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign tag_in          = r_tag;
  assign set_in          = r_set;
  assign state_in        = r_req_state;
  assign inv_ack_cnt_in  = r_req_inv;
  assign rsp_way         = r_rsp_way;
  assign rsp_state       = r_rsp_state;
  assign rsp_inv_ack_cnt = r_rsp_inv;
  assign flush_done      = r_flush_done;
  assign err_protocol    = r_err_protocol;
  assign err_timeout     = r_err_timeout;

endmodule

// File: tb/tb_l2_tag_req_sequencer.sv
// Bench for l2_tag_req_sequencer: table vectors, random lookups against a latency/payload model,
// and hand-written flush, timeout, protocol-error and reset sequences.
module tb_l2_tag_req_sequencer;
  localparam int TAG_W = 15, SET_W = 9, WAY_W = 3, STATE_W = 3, INV_W = 4, TIMEOUT = 8;

  logic clk, rst;
  logic req_valid, req_ready, req_has_state, req_has_inv;
  logic [TAG_W-1:0] req_tag;
  logic [SET_W-1:0] req_set;
  logic [STATE_W-1:0] req_state;
  logic [INV_W-1:0] req_inv_ack_cnt;
  logic flush_req_valid, flush_req_ready, flush_done;
  logic rsp_valid, rsp_ready;
  logic [WAY_W-1:0] rsp_way;
  logic [STATE_W-1:0] rsp_state;
  logic [INV_W-1:0] rsp_inv_ack_cnt;
  logic tag_in_valid, set_in_valid, state_in_valid, inv_ack_cnt_in_valid;
  logic tag_in_ready, set_in_ready, state_in_ready, inv_ack_cnt_in_ready;
  logic [TAG_W-1:0] tag_in;
  logic [SET_W-1:0] set_in;
  logic [STATE_W-1:0] state_in;
  logic [INV_W-1:0] inv_ack_cnt_in;
  logic way_out_valid, state_out_valid, inv_ack_cnt_out_valid;
  logic way_out_ready, state_out_ready, inv_ack_cnt_out_ready;
  logic [WAY_W-1:0] way_out;
  logic [STATE_W-1:0] state_out;
  logic [INV_W-1:0] inv_ack_cnt_out;
  logic flush_in_valid, flush_in_ready, flush_complete_valid, flush_complete_ready;
  logic err_protocol, err_timeout;

  l2_tag_req_sequencer #(.TAG_W(TAG_W), .SET_W(SET_W), .WAY_W(WAY_W), .STATE_W(STATE_W),
                         .INV_W(INV_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag), .req_set(req_set),
    .req_state(req_state), .req_inv_ack_cnt(req_inv_ack_cnt),
    .req_has_state(req_has_state), .req_has_inv(req_has_inv),
    .flush_req_valid(flush_req_valid), .flush_req_ready(flush_req_ready), .flush_done(flush_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_way(rsp_way), .rsp_state(rsp_state),
    .rsp_inv_ack_cnt(rsp_inv_ack_cnt),
    .tag_in_valid(tag_in_valid), .set_in_valid(set_in_valid), .state_in_valid(state_in_valid),
    .inv_ack_cnt_in_valid(inv_ack_cnt_in_valid),
    .tag_in_ready(tag_in_ready), .set_in_ready(set_in_ready), .state_in_ready(state_in_ready),
    .inv_ack_cnt_in_ready(inv_ack_cnt_in_ready),
    .tag_in(tag_in), .set_in(set_in), .state_in(state_in), .inv_ack_cnt_in(inv_ack_cnt_in),
    .way_out_valid(way_out_valid), .state_out_valid(state_out_valid),
    .inv_ack_cnt_out_valid(inv_ack_cnt_out_valid),
    .way_out_ready(way_out_ready), .state_out_ready(state_out_ready),
    .inv_ack_cnt_out_ready(inv_ack_cnt_out_ready),
    .way_out(way_out), .state_out(state_out), .inv_ack_cnt_out(inv_ack_cnt_out),
    .flush_in_valid(flush_in_valid), .flush_in_ready(flush_in_ready),
    .flush_complete_valid(flush_complete_valid), .flush_complete_ready(flush_complete_ready),
    .err_protocol(err_protocol), .err_timeout(err_timeout)
  );

  typedef struct {
    logic [TAG_W-1:0] tag;  logic [SET_W-1:0] sidx;
    logic has_st;           logic [STATE_W-1:0] st;
    logic has_inv;          logic [INV_W-1:0] inv;
    int d_tag, d_set, d_st, d_inv, d_way, st_at, d_rsp;
    logic give_st;          logic [STATE_W-1:0] st_rsp;
    logic give_inv;         logic [INV_W-1:0] inv_rsp;
    logic [WAY_W-1:0] way;
    int exp_lat;
    logic [WAY_W-1:0] exp_way; logic [STATE_W-1:0] exp_st; logic [INV_W-1:0] exp_inv;
  } vec_t;

  int n_checks = 0, n_pass = 0, cyc = 0;
  int g_acc_wait, g_wait_cyc, g_tmo_cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [63:0] all_outs();
    logic [63:0] o;
    o = {8'b0, req_ready, flush_req_ready, flush_done, rsp_valid, rsp_way, rsp_state, rsp_inv_ack_cnt,
         tag_in_valid, set_in_valid, state_in_valid, inv_ack_cnt_in_valid,
         tag_in, set_in, state_in, inv_ack_cnt_in,
         way_out_ready, state_out_ready, inv_ack_cnt_out_ready,
         flush_in_valid, flush_complete_ready, err_protocol, err_timeout};
    return o;
  endfunction

  function automatic vec_t mkv(input int tag, input int sidx, input bit has_st, input int st,
                               input bit has_inv, input int inv, input int d_tag, input int d_set,
                               input int d_st, input int d_inv, input int d_way, input bit give_st,
                               input int st_rsp, input bit give_inv, input int inv_rsp, input int way,
                               input int d_rsp, input int e_lat, input int e_way, input int e_st,
                               input int e_inv);
    vec_t v;
    v.tag = TAG_W'(tag); v.sidx = SET_W'(sidx); v.has_st = has_st; v.st = STATE_W'(st);
    v.has_inv = has_inv; v.inv = INV_W'(inv);
    v.d_tag = d_tag; v.d_set = d_set; v.d_st = d_st; v.d_inv = d_inv; v.d_way = d_way; v.st_at = 0;
    v.give_st = give_st; v.st_rsp = STATE_W'(st_rsp); v.give_inv = give_inv; v.inv_rsp = INV_W'(inv_rsp);
    v.way = WAY_W'(way); v.d_rsp = d_rsp;
    v.exp_lat = e_lat; v.exp_way = WAY_W'(e_way); v.exp_st = STATE_W'(e_st); v.exp_inv = INV_W'(e_inv);
    return v;
  endfunction

  // Reference: bank valids rise 1 cycle after acceptance, the slowest enabled channel gates entry
  // to the wait phase, the response appears the cycle after the way; fields not returned read 0.
  function automatic vec_t model(input vec_t v);
    int worst;
    worst = (v.d_tag > v.d_set) ? v.d_tag : v.d_set;
    if (v.has_st && v.d_st > worst) worst = v.d_st;
    if (v.has_inv && v.d_inv > worst) worst = v.d_inv;
    v.exp_lat = 1 + (worst + 1) + v.d_way + 1;
    v.exp_way = v.way;
    v.exp_st  = v.give_st ? v.st_rsp : '0;
    v.exp_inv = v.give_inv ? v.inv_rsp : '0;
    return v;
  endfunction

  task automatic clear_bank();
    tag_in_ready = 0; set_in_ready = 0; state_in_ready = 0; inv_ack_cnt_in_ready = 0;
    way_out_valid = 0; state_out_valid = 0; inv_ack_cnt_out_valid = 0; rsp_ready = 0;
    flush_in_ready = 0; flush_complete_valid = 0;
  endtask

  task automatic run_lookup(input vec_t v, input string nm);
    int n, aw, acc, wc, tc, sc, stc, ic, rc, t_first, s_first, last_vld, rsp_first;
    bit done, stable_ok, hold_ok;
    logic [WAY_W-1:0] h_way; logic [STATE_W-1:0] h_st; logic [INV_W-1:0] h_inv;
    n = 0; aw = 0; wc = 0; tc = 0; sc = 0; stc = 0; ic = 0; rc = 0;
    t_first = -1; s_first = -1; last_vld = -1; rsp_first = -1;
    done = 0; stable_ok = 1; hold_ok = 1; h_way = '0; h_st = '0; h_inv = '0;
    g_wait_cyc = -1; g_tmo_cyc = -1;
    @(negedge clk); #1;
    req_valid = 1; req_tag = v.tag; req_set = v.sidx; req_state = v.st; req_inv_ack_cnt = v.inv;
    req_has_state = v.has_st; req_has_inv = v.has_inv;
    #1;
    while (!req_ready && aw < 50) begin @(negedge clk); #2; aw++; end
    g_acc_wait = aw;
    acc = cyc;
    @(negedge clk); #1;
    req_valid = 0;
    req_tag = ~v.tag; req_set = ~v.sidx; req_state = ~v.st; req_inv_ack_cnt = ~v.inv;
    if (aw >= 50) begin chk({nm, ".accept"}, 0, 1); return; end
    while (!done && n < 200) begin
      if (tag_in_valid) begin
        if (t_first < 0) t_first = cyc;
        tc++; last_vld = cyc; if (tag_in !== v.tag) stable_ok = 0;
      end
      if (set_in_valid) begin
        if (s_first < 0) s_first = cyc;
        sc++; last_vld = cyc; if (set_in !== v.sidx) stable_ok = 0;
      end
      if (state_in_valid) begin stc++; last_vld = cyc; if (state_in !== v.st) stable_ok = 0; end
      if (inv_ack_cnt_in_valid) begin ic++; last_vld = cyc; if (inv_ack_cnt_in !== v.inv) stable_ok = 0; end
      tag_in_ready         = tag_in_valid && (tc > v.d_tag);
      set_in_ready         = set_in_valid && (sc > v.d_set);
      state_in_ready       = state_in_valid && (stc > v.d_st);
      inv_ack_cnt_in_ready = inv_ack_cnt_in_valid && (ic > v.d_inv);
      way_out_valid = 0; state_out_valid = 0; inv_ack_cnt_out_valid = 0;
      way_out = WAY_W'($urandom); state_out = STATE_W'($urandom); inv_ack_cnt_out = INV_W'($urandom);
      if (way_out_ready) begin
        if (wc == 0) g_wait_cyc = cyc;
        if (v.give_st && wc == v.st_at) begin state_out_valid = 1; state_out = v.st_rsp; end
        if (wc == v.d_way) begin
          way_out_valid = 1; way_out = v.way;
          if (v.give_inv) begin inv_ack_cnt_out_valid = 1; inv_ack_cnt_out = v.inv_rsp; end
        end
        wc++;
      end
      rsp_ready = 0;
      if (rsp_valid) begin
        if (rc == 0) begin rsp_first = cyc; h_way = rsp_way; h_st = rsp_state; h_inv = rsp_inv_ack_cnt; end
        else if ({rsp_way, rsp_state, rsp_inv_ack_cnt} !== {h_way, h_st, h_inv}) hold_ok = 0;
        if (req_ready) hold_ok = 0;
        rc++;
        if (rc > v.d_rsp) begin rsp_ready = 1; done = 1; end
      end
      if (err_timeout && g_tmo_cyc < 0) g_tmo_cyc = cyc;
      @(negedge clk); #1;
      n++;
    end
    clear_bank();
    chk({nm, ".completed"}, done, 1);
    if (!done) return;
    chk({nm, ".tag_vld_rise"}, t_first - acc, 1);
    chk({nm, ".set_vld_rise"}, s_first - acc, 1);
    chk({nm, ".tag_vld_cycles"}, tc, v.d_tag + 1);
    chk({nm, ".set_vld_cycles"}, sc, v.d_set + 1);
    chk({nm, ".state_vld_cycles"}, stc, v.has_st ? v.d_st + 1 : 0);
    chk({nm, ".inv_vld_cycles"}, ic, v.has_inv ? v.d_inv + 1 : 0);
    chk({nm, ".req_data_stable"}, stable_ok, 1);
    chk({nm, ".wait_after_sent"}, g_wait_cyc - last_vld, 1);
    chk({nm, ".latency"}, rsp_first - acc, v.exp_lat);
    chk({nm, ".rsp_way"}, h_way, v.exp_way);
    chk({nm, ".rsp_state"}, h_st, v.exp_st);
    chk({nm, ".rsp_inv"}, h_inv, v.exp_inv);
    chk({nm, ".rsp_vld_cycles"}, rc, v.d_rsp + 1);
    chk({nm, ".rsp_hold_stable"}, hold_ok, 1);
  endtask

  vec_t tbl[4];

  initial begin
    int fi_cnt, fw_cnt, f_cyc, bad;
    bit ok_rr, ok_fd, fl_end;
    vec_t tv;
    tbl[0] = mkv(16'h1234, 9'h005, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 3, 0, 5, 3, 0, 0);
    tbl[1] = mkv(16'h0abc, 9'h1ff, 1, 5, 1, 9, 0, 0, 3, 1, 0, 1, 2, 1, 12, 6, 0, 6, 6, 2, 12);
    tbl[2] = mkv(16'h7fff, 9'h000, 0, 0, 0, 0, 1, 2, 0, 0, 1, 1, 4, 0, 0, 7, 5, 6, 7, 4, 0);
    tbl[3] = mkv(16'h0001, 9'h100, 0, 0, 1, 15, 0, 0, 0, 2, 3, 0, 0, 1, 5, 0, 1, 8, 0, 0, 5);

    rst = 1; req_valid = 0; flush_req_valid = 0; req_has_state = 0; req_has_inv = 0;
    req_tag = '0; req_set = '0; req_state = '0; req_inv_ack_cnt = '0;
    way_out = '0; state_out = '0; inv_ack_cnt_out = '0;
    clear_bank();
    #3;
    chk("reset.all_outputs_zero", all_outs(), 64'd0);
    repeat (2) @(negedge clk);
    #1 rst = 0;
    #1;
    chk("reset.req_ready_after", req_ready, 1);
    chk("reset.flush_req_ready_after", flush_req_ready, 1);

    for (int i = 0; i < 4; i++) run_lookup(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 40; i++) begin
      vec_t r;
      r.tag = TAG_W'($urandom); r.sidx = SET_W'($urandom);
      r.has_st = 1'($urandom); r.st = STATE_W'($urandom);
      r.has_inv = 1'($urandom); r.inv = INV_W'($urandom);
      r.d_tag = $urandom_range(0, 3); r.d_set = $urandom_range(0, 3);
      r.d_st = $urandom_range(0, 3); r.d_inv = $urandom_range(0, 3);
      r.d_way = $urandom_range(0, 5); r.st_at = $urandom_range(0, r.d_way);
      r.give_st = 1'($urandom); r.st_rsp = STATE_W'($urandom);
      r.give_inv = 1'($urandom); r.inv_rsp = INV_W'($urandom);
      r.way = WAY_W'($urandom); r.d_rsp = $urandom_range(0, 3);
      r = model(r);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_lookup(r, $sformatf("rnd%0d", i));
    end
    chk("rnd.no_err_protocol", err_protocol, 0);
    chk("rnd.no_err_timeout", err_timeout, 0);

    // Flush and lookup requested together: flush goes first, lookup waits for flush_done.
    @(negedge clk); #1;
    flush_req_valid = 1; req_valid = 1; req_tag = 15'h0555; req_set = 9'h033;
    req_has_state = 0; req_has_inv = 0;
    #1;
    chk("flush.req_ready_blocked", req_ready, 0);
    chk("flush.flush_req_ready", flush_req_ready, 1);
    @(negedge clk); #1;
    flush_req_valid = 0;
    fi_cnt = 0; fw_cnt = 0; f_cyc = -1; ok_rr = 1; ok_fd = 1; fl_end = 0;
    for (int i = 0; i < 40 && !fl_end; i++) begin
      if (f_cyc >= 0 && cyc == f_cyc + 1) begin
        chk("flush.done_pulse", flush_done, 1);
        chk("flush.req_ready_after_done", req_ready, 1);
        req_valid = 0;
      end else if (f_cyc >= 0 && cyc == f_cyc + 2) begin
        chk("flush.done_one_cycle", flush_done, 0);
        fl_end = 1;
      end else begin
        if (req_ready) ok_rr = 0;
        if (flush_done) ok_fd = 0;
      end
      if (flush_in_valid) fi_cnt++;
      flush_in_ready = flush_in_valid && (fi_cnt >= 2);
      flush_complete_valid = 0;
      if (flush_complete_ready) begin
        if (fw_cnt == 2) begin flush_complete_valid = 1; f_cyc = cyc; end
        fw_cnt++;
      end
      @(negedge clk); #1;
    end
    clear_bank();
    req_valid = 0;
    chk("flush.sequence_ended", fl_end, 1);
    chk("flush.req_ready_low_during", ok_rr, 1);
    chk("flush.no_early_done", ok_fd, 1);
    chk("flush.in_valid_cycles", fi_cnt, 2);
    chk("flush.no_err_protocol", err_protocol, 0);
    run_lookup(tbl[0], "post_flush");
    chk("post_flush.accept_wait", g_acc_wait, 0);

    // Bank silent past the timeout; a late way still completes the response.
    tv = mkv(16'h2222, 9'h0aa, 0, 0, 0, 0, 0, 0, 0, 0, TIMEOUT + 3, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0);
    tv = model(tv);
    run_lookup(tv, "timeout");
    chk("timeout.rise_cycle", g_tmo_cyc - g_wait_cyc, TIMEOUT + 1);
    chk("timeout.sticky", err_timeout, 1);

    @(negedge clk); #1;
    chk("proto.clean_before", err_protocol, 0);
    way_out_valid = 1;
    @(negedge clk); #1;
    way_out_valid = 0;
    chk("proto.spurious_way", err_protocol, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("proto.sticky", err_protocol, 1);

    // Reset pulse while the lookup is still issuing.
    req_valid = 1; req_has_state = 1; req_has_inv = 0; req_tag = 15'h1357; req_set = 9'h024;
    #1;
    chk("rst_mid.accept", req_ready, 1);
    @(negedge clk); #1;
    req_valid = 0;
    chk("rst_mid.in_issue", tag_in_valid, 1);
    #1 rst = 1;
    #1;
    chk("rst_mid.all_outputs_zero", all_outs(), 64'd0);
    chk("rst_mid.flags_cleared", {err_protocol, err_timeout}, 2'b00);
    @(negedge clk); #1;
    rst = 0;
    bad = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (rsp_valid || tag_in_valid || state_in_valid || way_out_ready) bad++;
    end
    chk("rst_mid.abandoned", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/l2_tag_req_sequencer.md
# l2_tag_req_sequencer

Requester-side sequencer driving the L2 cache tag bank's lookup and flush flex channels. It accepts one lookup or flush command from the L2 controller and issues it to the tag bank, with exactly one operation in flight. It collects the way/state/inv_ack_cnt response and returns it upstream. It flags protocol violations and response timeouts from the bank. Evict and flush-drain output channels of the tag bank are serviced by the main cache, not by this block.

## Interface
- TAG_W, 15, tag width
- SET_W, 9, set index width
- WAY_W, 3, way index width
- STATE_W, 3, coherence state width
- INV_W, 4, invalidation-ack count width
- TIMEOUT, 8, max cycles in WAIT_RSP before err_timeout (≥7)

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  reset; asynchronous and active-high
- req_valid / req_ready  in / out  1  upstream lookup handshake
- req_tag, req_set, req_state, req_inv_ack_cnt  in  TAG_W/SET_W/STATE_W/INV_W  lookup payload
- req_has_state, req_has_inv  in  1  optional-field enables
- flush_req_valid / flush_req_ready  in / out  1  upstream flush handshake
- flush_done  out  1  one-cycle pulse when the bank reports flush complete
- rsp_valid / rsp_ready  out / in  1  upstream response handshake
- rsp_way, rsp_state, rsp_inv_ack_cnt  out  WAY_W/STATE_W/INV_W  response payload
- tag_in_valid, set_in_valid, state_in_valid, inv_ack_cnt_in_valid  out  1  bank request valids
- tag_in_ready, set_in_ready, state_in_ready, inv_ack_cnt_in_ready  in  1  bank request readies
- tag_in, set_in, state_in, inv_ack_cnt_in  out  widths as above  bank request data
- way_out_valid, state_out_valid, inv_ack_cnt_out_valid  in  1  bank response valids
- way_out_ready, state_out_ready, inv_ack_cnt_out_ready  out  1  bank response readies
- way_out, state_out, inv_ack_cnt_out  in  widths as above  bank response data
- flush_in_valid / flush_in_ready  out / in  1  bank flush request
- flush_complete_valid / flush_complete_ready  in / out  1  bank flush completion
- err_protocol, err_timeout  out  1  sticky error flags

## Operation
- FSM states: IDLE, ISSUE, WAIT_RSP, HOLD_RSP, FLUSH_ISSUE, FLUSH_WAIT.
- req_ready = (IDLE && !flush_req_valid). flush_req_ready = IDLE.
- IDLE: a flush has priority over a lookup in the same cycle. On flush_req_valid → FLUSH_ISSUE. On req_valid&&req_ready → latch payload and enables, go to ISSUE.
- ISSUE: tag_in_valid and set_in_valid rise together. state_in_valid rises in the same cycle iff has_state; inv_ack_cnt_in_valid likewise iff has_inv.
  - Each valid stays high with stable data until its ready is sampled high, then drops independently. A per-channel sent flag tracks this.
  - When all enabled channels are sent → WAIT_RSP.
- WAIT_RSP: way_out_ready, state_out_ready and inv_ack_cnt_out_ready are all 1.
  - state_out/inv_ack_cnt_out are captured whenever their valid is high; uncaptured fields return 0.
  - way_out_valid captures way_out and moves to HOLD_RSP.
  - A cycle counter starts at 0 on entry. When it reaches TIMEOUT, err_timeout is set and the FSM keeps waiting.
- HOLD_RSP: rsp_valid=1 with stable payload until rsp_ready, then IDLE. Capture registers clear on exit.
- FLUSH_ISSUE: flush_in_valid=1 until flush_in_ready, then FLUSH_WAIT.
- FLUSH_WAIT: flush_complete_ready=1. On flush_complete_valid, flush_done pulses for 1 cycle and the FSM returns to IDLE.
- err_protocol is set if any of these occur:
  - way_out_valid outside WAIT_RSP;
  - flush_complete_valid outside FLUSH_WAIT;
  - any *_out_valid during FLUSH_ISSUE/FLUSH_WAIT.
- Error flags are sticky until rst.

## Timing
- Reset (async, immediate): FSM IDLE, all outputs 0, including every valid/ready, rsp payload, flush_done and error flags. Sent flags and counter also clear.
- rst asserted mid-operation abandons the transaction; no response is produced after release.
- Request accepted at cycle 0 → bank valids high at cycle 1.
- Ready high at cycle n → that valid low at cycle n+1.
- way_out_valid at cycle k → rsp_valid at cycle k+1. Minimum req-to-rsp is 3 cycles.
- rsp_valid&&rsp_ready at cycle m → req_ready can be high at m+1. Back-to-back lookups are spaced ≥4 cycles.
- flush_complete_valid at cycle f → flush_done high at f+1 only.
- Timeout: err_timeout rises TIMEOUT+1 cycles after WAIT_RSP entry if no way_out_valid.

## Test plan
- Lookup tag=0x1234, set=0x05, no optional fields; bank ready immediately; way_out=3 two cycles later → tag_in/set_in_valid high exactly 1 cycle, state/inv valids never high, rsp_way=3, rsp_state=0.
- Lookup with has_state=1, has_inv=1; state_in_ready delayed 3 cycles → tag/set valids drop after 1 cycle, state_in_valid held 4 cycles with stable data, WAIT_RSP entered only afterwards.
- flush_req_valid and req_valid in the same IDLE cycle → flush issued first, req_ready=0 until flush_done pulses, then lookup accepted.
- rsp_ready held low 5 cycles → rsp_valid and payload stable for 6 cycles, req_ready=0 throughout.
- Bank never responds → err_timeout=1 at cycle TIMEOUT+1 after WAIT_RSP entry. A later way_out_valid still completes the response.
- Spurious way_out_valid in IDLE → err_protocol=1, sticky. rst pulse mid-ISSUE → all outputs 0 same cycle, flags cleared.
